memcpy_engine: RTL and testbench



---
 rtl/memcpy_engine_if.sv | 32 +++
 rtl/memcpy_engine.sv | 196 +++++++++++++++++++
 tb/tb_memcpy_engine.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/memcpy_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : memcpy_engine_if
// Purpose  : Control handshake and 8-lane DRAM bus bundle for memcpy_engine.
// Revision : 1.0  initial release
// ============================================================================
interface memcpy_engine_if;
    logic         en;
    logic [63:0]  src;
    logic [63:0]  dst;
    logic [14:0]  size;
    logic         done;
    logic [7:0]   dram_en;
    logic         dram_rdwr;
    logic [511:0] dram_addr;
    logic [63:0]  dram_data_out;
    logic [63:0]  dram_data_in;
    logic [7:0]   dram_valid;

    // Requester/DRAM side: starts copies and answers lane requests.
    modport master (
        output en, src, dst, size, dram_data_in, dram_valid,
        input  done, dram_en, dram_rdwr, dram_addr, dram_data_out
    );

    // Engine side.
    modport slave (
        input  en, src, dst, size, dram_data_in, dram_valid,
        output done, dram_en, dram_rdwr, dram_addr, dram_data_out
    );
endinterface
`default_nettype wire

// File: rtl/memcpy_engine.sv
`default_nettype none
// ============================================================================
// Module   : memcpy_engine
// Purpose  : Chunked 8-lane DRAM byte copy (read chunk, write chunk, repeat).
// Revision : 1.0  initial release
// ============================================================================
module memcpy_engine (
    input  wire logic       clk,
    input  wire logic       reset,
    memcpy_engine_if.slave  bus
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_read  = 2'd1;
    localparam logic [1:0] c_st_write = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]   r_state,    w_state_nx;
    logic [63:0]  r_src,      w_src_nx;
    logic [63:0]  r_dst,      w_dst_nx;
    logic [14:0]  r_size,     w_size_nx;
    logic [14:0]  r_offset,   w_offset_nx;
    logic [63:0]  r_buf,      w_buf_nx;
    logic [7:0]   r_mask,     w_mask_nx;
    logic         r_done,     w_done_nx;
    logic [7:0]   r_dram_en,  w_en_nx;
    logic         r_rdwr,     w_rdwr_nx;
    logic [511:0] r_addr,     w_addr_nx;
    logic [63:0]  r_data_out, w_data_nx;

    logic [14:0]  w_remain;
    logic [3:0]   w_n;
    logic [7:0]   w_used;
    logic [7:0]   w_hit;
    logic [7:0]   w_mask_new;
    logic         w_phase_done;
    logic [63:0]  w_buf_new;
    logic [14:0]  w_offset_adv;
    logic [7:0]   w_used_adv;
    logic         w_last;

    // Lane i takes part in a chunk when at least i+1 bytes remain.
    function automatic logic [7:0] f_lane_mask(input logic [14:0] remain);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) begin
            m[i] = (remain > 15'(i));
        end
        return m;
    endfunction

    function automatic logic [511:0] f_addrs(input logic [63:0] base, input logic [14:0] off);
        logic [511:0] a;
        for (int i = 0; i < 8; i++) begin
            a[64*i +: 64] = base + 64'(off) + 64'(i);
        end
        return a;
    endfunction

    assign w_remain     = r_size - r_offset;
    assign w_n          = (w_remain >= 15'd8) ? 4'd8 : w_remain[3:0];
    assign w_used       = f_lane_mask(w_remain);
    assign w_hit        = r_dram_en & bus.dram_valid;
    assign w_mask_new   = r_mask | w_hit;
    assign w_phase_done = ((w_mask_new & w_used) == w_used);
    assign w_offset_adv = r_offset + 15'(w_n);
    assign w_used_adv   = f_lane_mask(r_size - w_offset_adv);
    assign w_last       = (w_offset_adv >= r_size);

    always_comb begin
        w_buf_new = r_buf;
        for (int i = 0; i < 8; i++) begin
            if (w_hit[i]) begin
                w_buf_new[8*i +: 8] = bus.dram_data_in[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_src_nx    = r_src;
        w_dst_nx    = r_dst;
        w_size_nx   = r_size;
        w_offset_nx = r_offset;
        w_buf_nx    = r_buf;
        w_mask_nx   = r_mask;
        w_done_nx   = r_done;
        w_en_nx     = r_dram_en;
        w_rdwr_nx   = r_rdwr;
        w_addr_nx   = r_addr;
        w_data_nx   = r_data_out;

        case (r_state)
            c_st_idle: begin
                w_en_nx   = '0;
                w_done_nx = 1'b0;
                if (bus.en) begin
                    w_src_nx    = bus.src;
                    w_dst_nx    = bus.dst;
                    w_size_nx   = bus.size;
                    w_offset_nx = '0;
                    w_mask_nx   = '0;
                    if (bus.size == 15'd0) begin
                        w_state_nx = c_st_done;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_state_nx = c_st_read;
                    end
                end
            end

            c_st_read: begin
                // First READ cycle after IDLE only loads addresses; requests follow.
                w_rdwr_nx = 1'b0;
                w_addr_nx = f_addrs(r_src, r_offset);
                w_buf_nx  = w_buf_new;
                if (w_phase_done) begin
                    w_state_nx = c_st_write;
                    w_mask_nx  = '0;
                    w_en_nx    = w_used;
                    w_rdwr_nx  = 1'b1;
                    w_addr_nx  = f_addrs(r_dst, r_offset);
                    w_data_nx  = w_buf_new;
                end else begin
                    w_mask_nx = w_mask_new;
                    w_en_nx   = w_used & ~w_mask_new;
                end
            end

            c_st_write: begin
                if (w_phase_done) begin
                    w_offset_nx = w_offset_adv;
                    w_mask_nx   = '0;
                    if (w_last) begin
                        w_state_nx = c_st_done;
                        w_en_nx    = '0;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_state_nx = c_st_read;
                        w_en_nx    = w_used_adv;
                        w_rdwr_nx  = 1'b0;
                        w_addr_nx  = f_addrs(r_src, w_offset_adv);
                    end
                end else begin
                    w_mask_nx = w_mask_new;
                    w_en_nx   = w_used & ~w_mask_new;
                end
            end

            default: begin
                w_en_nx = '0;
                if (!bus.en) begin
                    w_state_nx = c_st_idle;
                    w_done_nx  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_src      <= '0;
            r_dst      <= '0;
            r_size     <= '0;
            r_offset   <= '0;
            r_buf      <= '0;
            r_mask     <= '0;
            r_done     <= 1'b0;
            r_dram_en  <= '0;
            r_rdwr     <= 1'b0;
            r_addr     <= '0;
            r_data_out <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_src      <= w_src_nx;
            r_dst      <= w_dst_nx;
            r_size     <= w_size_nx;
            r_offset   <= w_offset_nx;
            r_buf      <= w_buf_nx;
            r_mask     <= w_mask_nx;
            r_done     <= w_done_nx;
            r_dram_en  <= w_en_nx;
            r_rdwr     <= w_rdwr_nx;
            r_addr     <= w_addr_nx;
            r_data_out <= w_data_nx;
        end
    end

    assign bus.done          = r_done;
    assign bus.dram_en       = r_dram_en;
    assign bus.dram_rdwr     = r_rdwr;
    assign bus.dram_addr     = r_addr;
    assign bus.dram_data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_memcpy_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_memcpy_engine
// Purpose  : Randomized scoreboard bench for memcpy_engine with a DRAM model.
// Revision : 1.0  initial release
// ============================================================================
module tb_memcpy_engine;

    typedef struct packed {
        logic        rdwr;
        logic [7:0]  mask;
        logic [63:0] base;
        logic [63:0] data;
    } phase_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    memcpy_engine_if bus();
    memcpy_engine dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int errors = 0;
    int checks = 0;

    logic [7:0] mem     [logic [63:0]];
    logic [7:0] ref_mem [logic [63:0]];
    phase_t     exp_q[$];
    logic [7:0] lanes_seen;
    logic [7:0] lanes_exp;
    int         max_lat;
    logic [7:0] busy;
    int         cnt [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rd(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    // DRAM model: each requesting lane answers after a random number of cycles.
    initial begin
        bus.dram_valid   = '0;
        bus.dram_data_in = '0;
        busy             = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy           = '0;
                bus.dram_valid = '0;
            end else begin
                for (int i = 0; i < 8; i++) begin
                    logic [63:0] a;
                    if (bus.dram_valid[i]) begin
                        bus.dram_valid[i] = 1'b0;
                        busy[i]           = 1'b0;
                    end
                    if (bus.dram_en[i] && !busy[i]) begin
                        busy[i] = 1'b1;
                        cnt[i]  = $urandom_range(0, max_lat);
                    end
                    if (busy[i] && !bus.dram_valid[i]) begin
                        if (cnt[i] == 0) begin
                            bus.dram_valid[i] = 1'b1;
                            a = bus.dram_addr[64*i +: 64];
                            if (bus.dram_rdwr) mem[a] = bus.dram_data_out[8*i +: 8];
                            else bus.dram_data_in[8*i +: 8] = rd(a);
                        end else begin
                            cnt[i]--;
                        end
                    end
                end
            end
        end
    end

    // Monitor: every new lane phase is popped from the scoreboard and compared.
    initial begin
        logic [7:0]   prev_en;
        logic         prev_rdwr;
        logic [511:0] prev_addr;
        logic [63:0]  prev_data;
        phase_t       cur;
        prev_en = '0; prev_rdwr = 1'b0; prev_addr = '0; prev_data = '0; cur = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_en = '0;
            end else begin
                lanes_seen = lanes_seen | bus.dram_en;
                if (bus.dram_en != 8'd0 && (prev_en == 8'd0 || prev_rdwr != bus.dram_rdwr)) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_phase", {56'd0, bus.dram_en}, 64'd0);
                        cur = '0;
                        cur.mask = 8'hff;
                    end else begin
                        cur = exp_q.pop_front();
                        check("phase_rdwr", {63'd0, bus.dram_rdwr}, {63'd0, cur.rdwr});
                        check("phase_lanes", {56'd0, bus.dram_en}, {56'd0, cur.mask});
                        for (int i = 0; i < 8; i++) begin
                            if (cur.mask[i]) begin
                                check("lane_addr", bus.dram_addr[64*i +: 64], cur.base + 64'(i));
                                if (cur.rdwr)
                                    check("lane_wdata", {56'd0, bus.dram_data_out[8*i +: 8]},
                                          {56'd0, cur.data[8*i +: 8]});
                            end
                        end
                    end
                end else if (bus.dram_en != 8'd0) begin
                    check("lane_subset", {56'd0, bus.dram_en & ~cur.mask}, 64'd0);
                    check("phase_stable", {63'd0, (prev_addr == bus.dram_addr) &&
                          (prev_data == bus.dram_data_out)}, 64'd1);
                end
                prev_en   = bus.dram_en;
                prev_rdwr = bus.dram_rdwr;
                prev_addr = bus.dram_addr;
                prev_data = bus.dram_data_out;
            end
        end
    end

    // Reference: ascending chunks of up to 8 bytes, each read fully then written.
    task automatic plan(input logic [63:0] s, input logic [63:0] d, input logic [14:0] sz);
        int          n;
        logic [63:0] data;
        logic [7:0]  m;
        phase_t      p;
        ref_mem   = mem;
        lanes_exp = '0;
        n = 0;
        for (int off = 0; off < int'(sz); off += n) begin
            n = (int'(sz) - off >= 8) ? 8 : int'(sz) - off;
            m = 8'((1 << n) - 1);
            data = '0;
            for (int i = 0; i < n; i++) data[8*i +: 8] = ref_rd(s + 64'(off + i));
            p.rdwr = 1'b0; p.mask = m; p.base = s + 64'(off); p.data = '0;
            exp_q.push_back(p);
            for (int i = 0; i < n; i++) ref_mem[d + 64'(off + i)] = data[8*i +: 8];
            p.rdwr = 1'b1; p.base = d + 64'(off); p.data = data;
            exp_q.push_back(p);
            lanes_exp = lanes_exp | m;
        end
    endtask

    task automatic run_copy(input logic [63:0] s, input logic [63:0] d,
                            input logic [14:0] sz, input bit drop_en);
        int cyc;
        plan(s, d, sz);
        lanes_seen = '0;
        @(negedge clk);
        bus.src = s; bus.dst = d; bus.size = sz; bus.en = 1'b1;
        @(negedge clk);
        bus.src  = {$urandom, $urandom};
        bus.dst  = {$urandom, $urandom};
        bus.size = 15'($urandom);
        cyc = 0;
        while (!bus.done && cyc < 5000) begin
            if (drop_en && cyc == 2) bus.en = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check("done_seen", {63'd0, bus.done}, 64'd1);
        if (sz == 15'd0) check("zero_size_latency", 64'(cyc), 64'd0);
        check("phases_left", 64'(exp_q.size()), 64'd0);
        check("lanes_used", {56'd0, lanes_seen}, {56'd0, lanes_exp});
        if (bus.en) begin
            @(negedge clk);
            check("done_hold", {63'd0, bus.done}, 64'd1);
            bus.en = 1'b0;
        end
        @(negedge clk);
        check("done_clear", {63'd0, bus.done}, 64'd0);
        for (int i = 0; i <= int'(sz) + 1; i++)
            check("dst_byte", {56'd0, rd(d + 64'(i) - 64'd1)}, {56'd0, ref_rd(d + 64'(i) - 64'd1)});
        for (int i = 0; i < int'(sz); i++)
            check("src_byte", {56'd0, rd(s + 64'(i))}, {56'd0, ref_rd(s + 64'(i))});
        exp_q.delete();
    endtask

    initial begin
        logic [7:0]  pat [16];
        logic [63:0] s, d;
        logic [14:0] sz;
        int          cyc;
        pat = '{8'hbe, 8'hef, 8'hba, 8'had, 8'hde, 8'had, 8'hb1, 8'h6d,
                8'h06, 8'h01, 8'h02, 8'h34, 8'h56, 8'h78, 8'h61, 8'h11};
        reset = 1'b1; bus.en = 1'b0; bus.src = '0; bus.dst = '0; bus.size = '0;
        max_lat = 2; lanes_seen = '0; lanes_exp = '0;
        repeat (2) @(negedge clk);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_en", {56'd0, bus.dram_en}, 64'd0);
        check("rst_rdwr", {63'd0, bus.dram_rdwr}, 64'd0);
        check("rst_addr", {63'd0, |bus.dram_addr}, 64'd0);
        check("rst_wdata", bus.dram_data_out, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        mem[64'h100] = 8'hbe;
        run_copy(64'h100, 64'h3FF, 15'd1, 1'b0);
        check("single_byte", {56'd0, rd(64'h3FF)}, 64'hbe);

        for (int i = 0; i < 16; i++) mem[64'h100 + 64'(i)] = pat[i];
        run_copy(64'h100, 64'h200, 15'd16, 1'b0);
        for (int i = 0; i < 16; i++) begin
            check("chunk2_dst", {56'd0, rd(64'h200 + 64'(i))}, {56'd0, pat[i]});
            check("chunk2_src", {56'd0, rd(64'h100 + 64'(i))}, {56'd0, pat[i]});
        end

        run_copy(64'h100, 64'h300, 15'd11, 1'b0);
        check("partial_guard", {56'd0, rd(64'h30B)}, 64'h00);

        run_copy(64'h500, 64'h600, 15'd0, 1'b0);

        max_lat = 6;
        run_copy(64'h100, 64'h700, 15'd8, 1'b0);
        max_lat = 2;

        // Reset during a write phase, then a fresh copy.
        plan(64'h100, 64'h800, 15'd24);
        @(negedge clk);
        bus.src = 64'h100; bus.dst = 64'h800; bus.size = 15'd24; bus.en = 1'b1;
        cyc = 0;
        while (!(bus.dram_rdwr && bus.dram_en != 8'd0) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("reached_write", {63'd0, bus.dram_rdwr}, 64'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_done", {63'd0, bus.done}, 64'd0);
        check("mid_rst_en", {56'd0, bus.dram_en}, 64'd0);
        check("mid_rst_rdwr", {63'd0, bus.dram_rdwr}, 64'd0);
        check("mid_rst_addr", {63'd0, |bus.dram_addr}, 64'd0);
        check("mid_rst_wdata", bus.dram_data_out, 64'd0);
        exp_q.delete();
        bus.en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_copy(64'h100, 64'h800, 15'd24, 1'b0);

        for (int t = 0; t < 20; t++) begin
            case ($urandom_range(0, 3))
                0: begin s = {$urandom, $urandom}; d = {$urandom, $urandom}; end
                1: begin s = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
                         d = {$urandom, $urandom}; end
                2: begin s = {32'd0, $urandom}; d = s + 64'($urandom_range(0, 10)); end
                default: begin s = {32'd0, $urandom}; d = s - 64'($urandom_range(1, 10)); end
            endcase
            sz = 15'($urandom_range(0, 40));
            for (int i = 0; i < int'(sz); i++) mem[s + 64'(i)] = 8'($urandom);
            max_lat = $urandom_range(0, 5);
            run_copy(s, d, sz, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
